ddr_out_gearbox: RTL

- Parallel-to-DDR serializer that sits directly upstream of the two-edge DDR output register.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Drives that register's D0/D1 data pair and CE, emitting 2 bits per C cycle with no gaps between back-to-back words.
- Inserts a defined idle level when no data is available.

---
 rtl/ddr_out_gearbox_pkg.sv | 30 +++
 rtl/ddr_gear_hold.sv | 35 +++
 rtl/ddr_out_gearbox.sv | 97 +++++++++
 3 files changed

// File: rtl/ddr_out_gearbox_pkg.sv
// Shared helpers for the DDR gearbox pair: word geometry and bit-pair extraction.
// The DDR input deserializer uses the same pair ordering.
package ddr_out_gearbox_pkg;

   localparam int MAX_W = 64;

   function automatic int pairs_of(input int width);
      return width / 2;
   endfunction

   function automatic int cnt_w_of(input int width);
      return $clog2(width / 2) + 1;
   endfunction

   // Returns {d1, d0} for pair k of a word that occupies word[width-1:0].
   function automatic logic [1:0] pair_get(input logic [MAX_W-1:0] word, input int width,
                                           input int k, input logic msb_first);
      logic [1:0] t;
      logic [1:0] p;
      if (msb_first) begin
         t = 2'(word >> (width - 2 - 2 * k));
         p = {t[0], t[1]};
      end else begin
         t = 2'(word >> (2 * k));
         p = t;
      end
      return p;
   endfunction

endpackage

// File: rtl/ddr_gear_hold.sv
// One-entry hold register in front of the gearbox shift register.
// Ready depends only on registered state so it never follows the valid input.
module ddr_gear_hold #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             cnt_zero,
   input  logic             drain,
   output logic             in_ready,
   output logic [WIDTH-1:0] hold,
   output logic             hold_v
);

   logic accept;

   assign in_ready = !hold_v | cnt_zero;
   assign accept   = in_valid & in_ready;

   // An accept on the same edge as a drain refills the entry, so it wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold   <= '0;
         hold_v <= 1'b0;
      end else if (accept) begin
         hold   <= in_data;
         hold_v <= 1'b1;
      end else if (drain) begin
         hold_v <= 1'b0;
      end
   end

endmodule

// File: rtl/ddr_out_gearbox.sv
// Parallel-to-DDR serializer: turns WIDTH-bit words into back-to-back D0/D1 pairs
// with CE for a two-edge output register, idling at IDLE_VAL when starved.
module ddr_out_gearbox
   import ddr_out_gearbox_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter logic IDLE_VAL  = 1'b0,
   parameter logic MSB_FIRST = 1'b0
) (
   input  logic             C,
   input  logic             R_N,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic             D0,
   output logic             D1,
   output logic             CE,
   output logic             BUSY,
   output logic             UNDERRUN
);

   localparam int PAIRS = pairs_of(WIDTH);
   localparam int CNT_W = cnt_w_of(WIDTH);

   generate
      if ((WIDTH < 2) || (WIDTH % 2 != 0) || (WIDTH > MAX_W)) begin : g_bad_width
         $error("ddr_out_gearbox: WIDTH must be even, >= 2 and <= MAX_W");
      end
   endgenerate

   logic [WIDTH-1:0] hold;
   logic             hold_v;
   logic [WIDTH-1:0] sr, sr_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             d0_n, d1_n, ce_n, take;
   logic [1:0]       p_sr, p_hold;

   ddr_gear_hold #(.WIDTH(WIDTH)) u_hold (
      .clk      (C),
      .rst_n    (R_N),
      .in_data  (IN_DATA),
      .in_valid (IN_VALID),
      .cnt_zero (cnt == '0),
      .drain    (take),
      .in_ready (IN_READY),
      .hold     (hold),
      .hold_v   (hold_v)
   );

   // The next pair to emit always sits at pair 0 of whichever word is the source.
   assign p_sr   = pair_get(MAX_W'(sr), WIDTH, 0, MSB_FIRST);
   assign p_hold = pair_get(MAX_W'(hold), WIDTH, 0, MSB_FIRST);

   always_comb begin
      d0_n  = IDLE_VAL;
      d1_n  = IDLE_VAL;
      ce_n  = 1'b0;
      cnt_n = cnt;
      sr_n  = sr;
      take  = 1'b0;
      if (cnt != '0) begin
         d0_n  = p_sr[0];
         d1_n  = p_sr[1];
         sr_n  = MSB_FIRST ? (sr << 2) : (sr >> 2);
         cnt_n = cnt - 1'b1;
         ce_n  = 1'b1;
      end else if (hold_v) begin
         take  = 1'b1;
         d0_n  = p_hold[0];
         d1_n  = p_hold[1];
         sr_n  = MSB_FIRST ? (hold << 2) : (hold >> 2);
         cnt_n = CNT_W'(PAIRS - 1);
         ce_n  = 1'b1;
      end
   end

   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         D0       <= IDLE_VAL;
         D1       <= IDLE_VAL;
         CE       <= 1'b0;
         UNDERRUN <= 1'b0;
         cnt      <= '0;
         sr       <= '0;
      end else begin
         D0       <= d0_n;
         D1       <= d1_n;
         CE       <= ce_n;
         UNDERRUN <= CE & !ce_n;
         cnt      <= cnt_n;
         sr       <= sr_n;
      end
   end

   assign BUSY = CE | hold_v;

endmodule
